keypad_digit_loader: RTL and testbench

Debounces the digit code and no-key flag from the keypad priority encoder and shifts each accepted keypress into a 4-digit BCD entry register (MM:SS, most recent digit in the least significant nibble). It sits between the keypad encoder and the cook-timer load logic. It emits a one-cycle strobe per accepted digit and keeps a digit count so the timer controller knows when entry is complete.

---
 rtl/keypad_digit_loader.sv | 185 ++++++++++++++++++
 tb/tb_keypad_digit_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_loader.sv
`default_nettype none
// ============================================================================
// Module      : keypad_digit_loader
// Description : Debounces keypad presses and shifts accepted BCD digits into
//               a 4-digit MM:SS entry register. Optional held-key auto-repeat
//               is enabled by defining KEYPAD_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_entry,
    input  logic [3:0]  D,
    input  logic        no_key,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        full,
    output logic        key_strobe
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam bit                 c_db_one  = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_bad_params
        $error("keypad_digit_loader: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]         r_cand, w_cand_nxt, w_acc_digit;
    logic               w_accept;
    logic               w_rpt_hit;
    logic [15:0]        r_digits;
    logic [2:0]         r_count;
    logic               r_strobe;

    assign w_cnt_inc = r_cnt + c_cnt_one;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int                 c_rpt_w    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rpt_w-1:0] c_rpt_last = c_rpt_w'(REPEAT_CYCLES);

    logic [c_rpt_w-1:0] r_rpt, w_rpt_inc;
    logic               w_rpt_run;

    // Counter only advances while the same key stays down in HELD.
    assign w_rpt_run = (r_state == ST_HELD) && enable && !no_key && (D == r_cand);
    assign w_rpt_inc = r_rpt + c_rpt_w'(1);
    assign w_rpt_hit = w_rpt_run && (w_rpt_inc == c_rpt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt <= '0;
        end else if (w_rpt_run && !w_rpt_hit) begin
            r_rpt <= w_rpt_inc;
        end else begin
            r_rpt <= '0;
        end
    end
`else
    assign w_rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_acc_digit = r_cand;
        w_accept    = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!no_key) begin
                        w_cand_nxt  = D;
                        w_acc_digit = D;
                        if (c_db_one) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_PRESS;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                ST_PRESS: begin
                    if (no_key || (D != r_cand)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == c_db_last) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (no_key) begin
                        // A single-sample debounce finishes the release at once.
                        if (c_db_one) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end else if (w_rpt_hit) begin
                        w_accept = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!no_key) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == c_db_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Clear has priority over a coincident accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= 16'h0000;
            r_count  <= 3'd0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (clear_entry) begin
                r_digits <= 16'h0000;
                r_count  <= 3'd0;
            end else if (w_accept && !full) begin
                r_digits <= {r_digits[11:0], w_acc_digit};
                r_count  <= r_count + 3'd1;
                r_strobe <= 1'b1;
            end
        end
    end

    assign digits      = r_digits;
    assign digit_count = r_count;
    assign full        = (r_count == 3'd4);
    assign key_strobe  = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_digit_loader
// Description : Self-checking bench: vector table, directed corner sequences
//               and random presses against a window-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_loader;

    localparam int DC   = 4;
    localparam int RC   = 8;
    localparam int MAXT = 16384;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, clear_entry, no_key;
    logic [3:0]  D;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        full, key_strobe;

    always #5 clk = ~clk;

    keypad_digit_loader #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_CYCLES  (RC)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_entry(clear_entry),
        .D          (D),
        .no_key     (no_key),
        .digits     (digits),
        .digit_count(digit_count),
        .full       (full),
        .key_strobe (key_strobe)
    );

    typedef struct {
        bit          en;
        bit          clr;
        bit          nk;
        logic [3:0]  d;
        logic [15:0] e_digits;
        logic [2:0]  e_count;
        bit          e_strobe;
    } vec_t;

    int n_cmp = 0, n_fail = 0, n_strobes = 0, t = 0;

    // Sample history indexed by edge number.
    bit         h_nk[MAXT];
    logic [3:0] h_d[MAXT];

    // Model: a press is accepted once DC identical pressed samples, all taken
    // at or after m_armed, have been seen; release is DC consecutive no-key samples.
    bit          m_held;
    int          m_armed, m_rel_start, m_anchor;
    logic [3:0]  m_cand;
    logic [15:0] m_digits;
    int          m_count;
    bit          m_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    function automatic bit window_ok(input int tt);
        for (int i = tt - DC + 1; i <= tt; i++)
            if (h_nk[i] || h_d[i] != h_d[tt]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit en, input bit clr, input bit nk, input logic [3:0] d);
        bit acc = 1'b0;
        h_nk[t] = nk;
        h_d[t]  = d;
        if (!en) begin
            m_held      = 1'b0;
            m_rel_start = -1;
            m_armed     = t + 1;
        end else if (m_held) begin
            if (nk) begin
                if (m_rel_start < 0) m_rel_start = t;
                if (t - m_rel_start + 1 >= DC) begin
                    m_held      = 1'b0;
                    m_rel_start = -1;
                    m_armed     = t + 1;
                end
            end else if (m_rel_start >= 0) begin
                m_rel_start = -1;
                m_anchor    = t;
            end else if (d != m_cand) begin
                m_anchor = t;
            end else if (AR && (t - m_anchor == RC)) begin
                acc      = 1'b1;
                m_anchor = t;
            end
        end else if (!nk && (t - DC + 1 >= m_armed) && window_ok(t)) begin
            acc         = 1'b1;
            m_held      = 1'b1;
            m_cand      = d;
            m_anchor    = t;
            m_rel_start = -1;
        end else if (t >= 1 && t - 1 >= m_armed && !h_nk[t-1] && (nk || d != h_d[t-1])) begin
            m_armed = t + 1;
        end

        m_strobe = 1'b0;
        if (clr) begin
            m_digits = 16'h0000;
            m_count  = 0;
        end else if (acc && m_count < 4) begin
            m_digits = (m_digits << 4) | {12'h000, d};
            m_count++;
            m_strobe = 1'b1;
        end
        t++;
    endtask

    task automatic step(input bit en, input bit clr, input bit nk, input logic [3:0] d);
        enable      = en;
        clear_entry = clr;
        no_key      = nk;
        D           = d;
        @(posedge clk);
        #1;
        model_edge(en, clr, nk, d);
        check("digits", digits, m_digits);
        check("count", digit_count, m_count);
        check("full", full, (m_count == 4));
        check("strobe", key_strobe, m_strobe);
        if (key_strobe === 1'b1) n_strobes++;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        repeat (hold) step(1'b1, 1'b0, 1'b0, d);
        repeat (rel)  step(1'b1, 1'b0, 1'b1, d);
    endtask

    vec_t tbl[$];

    task automatic add_row(input bit nk, input logic [3:0] d, input bit clr,
                           input logic [15:0] ed, input logic [2:0] ec, input bit es);
        vec_t v;
        v.en = 1'b1; v.clr = clr; v.nk = nk; v.d = d;
        v.e_digits = ed; v.e_count = ec; v.e_strobe = es;
        tbl.push_back(v);
    endtask

    initial begin
        // Hold 5 for 10 cycles: accept on the 4th sample, then release and clear.
        for (int i = 0; i < 10; i++)
            add_row(1'b0, 4'd5, 1'b0, (i >= 3) ? 16'h0005 : 16'h0000,
                    (i >= 3) ? 3'd1 : 3'd0, (i == 3));
        for (int i = 0; i < 6; i++) add_row(1'b1, 4'd0, 1'b0, 16'h0005, 3'd1, 1'b0);
        add_row(1'b1, 4'd0, 1'b1, 16'h0000, 3'd0, 1'b0);

        reset = 1'b1; enable = 1'b0; clear_entry = 1'b0; no_key = 1'b1; D = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", digits, 16'h0000);
        check("rst_count", digit_count, 3'd0);
        check("rst_full", full, 1'b0);
        check("rst_strobe", key_strobe, 1'b0);
        reset = 1'b0;
        m_held = 1'b0; m_armed = 0; m_rel_start = -1; m_anchor = 0;
        m_cand = 4'd0; m_digits = 16'h0000; m_count = 0; m_strobe = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].nk, tbl[i].d);
            check("tbl_digits", digits, tbl[i].e_digits);
            check("tbl_count", digit_count, tbl[i].e_count);
            check("tbl_strobe", key_strobe, tbl[i].e_strobe);
        end

        // Fill to four digits, then a fifth press is discarded.
        n_strobes = 0;
        press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6); press(4'd0, 6, 6);
        check("fill_digits", digits, 16'h1230);
        check("fill_full", full, 1'b1);
        check("fill_strobes", n_strobes, 4);
        press(4'd9, 6, 6);
        check("fifth_digits", digits, 16'h1230);
        check("fifth_strobes", n_strobes, 4);
        step(1'b1, 1'b1, 1'b1, 4'd0);

        // Short glitches never reach the debounce threshold.
        n_strobes = 0;
        repeat (5) press(4'd7, 2, 2);
        check("glitch_strobes", n_strobes, 0);
        check("glitch_digits", digits, 16'h0000);

        // D changing while held is ignored.
        n_strobes = 0;
        press(4'd4, 4, 0);
        press(4'd6, 20, 6);
        check("dchg_strobes", n_strobes, 1);
        check("dchg_digits", digits, 16'h0004);

        // Clear coinciding with the accept edge drops the digit.
        step(1'b1, 1'b1, 1'b1, 4'd0);
        n_strobes = 0;
        press(4'd8, 3, 0);
        step(1'b1, 1'b1, 1'b0, 4'd8);
        check("clracc_strobe", key_strobe, 1'b0);
        check("clracc_digits", digits, 16'h0000);
        press(4'd8, 4, 6);
        check("clracc_count", digit_count, 3'd0);
        check("clracc_strobes", n_strobes, 0);
        press(4'd8, 6, 6);
        check("reentry_digits", digits, 16'h0008);

`ifdef KEYPAD_AUTOREPEAT_EN
        step(1'b1, 1'b1, 1'b1, 4'd0);
        n_strobes = 0;
        press(4'd2, 30, 6);
        check("rpt_strobes", n_strobes, 4);
        check("rpt_digits", digits, 16'h2222);
        check("rpt_full", full, 1'b1);
`endif

        // Random press/release traffic with occasional clear, enable drop and D change.
        for (int s = 0; s < 220; s++) begin
            automatic logic [3:0] kd = 4'($urandom_range(9));
            automatic int hl = $urandom_range(1, 9);
            automatic int rl = $urandom_range(1, 7);
            automatic bit chg = ($urandom_range(7) == 0);
            for (int i = 0; i < hl; i++)
                step(($urandom_range(31) != 0), ($urandom_range(24) == 0), 1'b0,
                     (chg && i >= hl / 2) ? 4'((kd + 1) % 10) : kd);
            for (int i = 0; i < rl; i++)
                step(($urandom_range(31) != 0), ($urandom_range(24) == 0),
                     ($urandom_range(15) != 0), 4'($urandom_range(9)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
